// File: rtl/sram_datapath_ctrl_pkg.sv
// Shared opcode and FSM state types for the SRAM datapath controller.
package datapath_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_COPY  = 2'b10,
      OP_SWAP  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_A,
      S_WAIT_A,
      S_RD_B,
      S_WAIT_B,
      S_WR_A,
      S_WR_B,
      S_DONE
   } state_t;

endpackage

// File: rtl/sram_datapath_ctrl_flex_counter.sv
// Loadable down-counter that times the SRAM read-latency wait states.
module flex_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && count != '0) begin
         count <= count - 1'b1;
      end
   end

   // Flags the enabled edge on which the count reaches zero.
   assign zero = en && (count == WIDTH'(1));

endmodule

// File: rtl/sram_datapath_ctrl.sv
// Single-port SRAM command sequencer: READ, WRITE, COPY and SWAP.
// SWAP is built only when DATAPATH_SWAP_EN is defined; otherwise op 11 completes with err.
module sram_datapath_ctrl
   import datapath_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [1:0]        op_code,
   input  logic [ADDR_W-1:0] address_one,
   input  logic [ADDR_W-1:0] address_two,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_ren,
   output logic              sram_wen
);

   localparam int CNT_W = $clog2(RD_LAT + 1);
`ifdef DATAPATH_SWAP_EN
   localparam bit SWAP_EN = 1'b1;
`else
   localparam bit SWAP_EN = 1'b0;
`endif

   state_t            state, state_nxt;
   op_t               op_q;
   logic [ADDR_W-1:0] a1_q, a2_q;
   logic [DATA_W-1:0] din_q;
   logic [DATA_W-1:0] wr_a_data, wr_b_data;
   logic              accept, cnt_load, cnt_en, cnt_zero;

   assign accept   = (state == S_IDLE) && start;
   assign cnt_load = (state == S_RD_A) || (state == S_RD_B);
   assign cnt_en   = (state == S_WAIT_A) || (state == S_WAIT_B);

   flex_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (CNT_W'(RD_LAT)),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               case (op_t'(op_code))
                  OP_READ, OP_COPY: state_nxt = S_RD_A;
                  OP_WRITE:         state_nxt = S_WR_A;
                  default:          state_nxt = SWAP_EN ? S_RD_A : S_DONE;
               endcase
            end
         end
         S_RD_A:   state_nxt = S_WAIT_A;
         S_WAIT_A: begin
            if (cnt_zero) begin
               case (op_q)
                  OP_READ: state_nxt = S_DONE;
                  OP_COPY: state_nxt = S_WR_B;
                  default: state_nxt = S_RD_B;
               endcase
            end
         end
         S_RD_B:   state_nxt = S_WAIT_B;
         S_WAIT_B: if (cnt_zero) state_nxt = S_WR_A;
         S_WR_A:   state_nxt = (op_q == OP_WRITE) ? S_DONE : S_WR_B;
         S_WR_B:   state_nxt = S_DONE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command fields only matter while busy, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q  <= op_t'(op_code);
         a1_q  <= address_one;
         a2_q  <= address_two;
         din_q <= data_in;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data_out <= '0;
         err      <= 1'b0;
      end else begin
         if (state == S_WAIT_A && cnt_zero) begin
            data_out <= sram_rdata;
         end
         if (accept) begin
            err <= (op_t'(op_code) == OP_SWAP) && !SWAP_EN;
         end else if (state == S_DONE) begin
            err <= 1'b0;
         end
      end
   end

`ifdef DATAPATH_SWAP_EN
   logic [DATA_W-1:0] tmp_a, tmp_b;

   always_ff @(posedge clk) begin
      if (state == S_WAIT_A && cnt_zero) tmp_a <= sram_rdata;
      if (state == S_WAIT_B && cnt_zero) tmp_b <= sram_rdata;
   end

   assign wr_a_data = (op_q == OP_WRITE) ? din_q : tmp_b;
   assign wr_b_data = (op_q == OP_SWAP) ? tmp_a : data_out;
`else
   assign wr_a_data = din_q;
   assign wr_b_data = data_out;
`endif

   // Bus is driven purely from state so an async reset drops it at once.
   always_comb begin
      sram_ren   = 1'b0;
      sram_wen   = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      case (state)
         S_RD_A: begin
            sram_ren  = 1'b1;
            sram_addr = a1_q;
         end
         S_RD_B: begin
            sram_ren  = 1'b1;
            sram_addr = a2_q;
         end
         S_WR_A: begin
            sram_wen   = 1'b1;
            sram_addr  = a1_q;
            sram_wdata = wr_a_data;
         end
         S_WR_B: begin
            sram_wen   = 1'b1;
            sram_addr  = a2_q;
            sram_wdata = wr_b_data;
         end
         default: ;
      endcase
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: doc/sram_datapath_ctrl.md
Name: sram_datapath_ctrl

Overview:
- Parametrised successor to the fixed-width SRAM datapath: sequences single-port SRAM accesses for one command at a time.
- Sits between the command/control logic and the SRAM model.
- Supports READ, WRITE, COPY and an optional SWAP, with configurable data width, address width and SRAM read latency.
- Start/busy/done handshake toward the controller.

Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 7, SRAM address width in bits
- RD_LAT, 1, SRAM read latency in cycles from the ren cycle to valid sram_rdata; must be >= 1

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  command valid; accepted only when busy=0
- op_code  in  2  00 READ, 01 WRITE, 10 COPY, 11 SWAP
- address_one  in  ADDR_W  primary address
- address_two  in  ADDR_W  secondary address (COPY destination, SWAP partner)
- data_in  in  DATA_W  write data (WRITE only)
- data_out  out  DATA_W  result word
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; illegal opcode
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data
- sram_ren  out  1  SRAM read enable
- sram_wen  out  1  SRAM write enable

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latency counter 0.
- Reset is asynchronous and may occur mid-operation. It aborts the command immediately: ren/wen drop at once and no partial write completes afterward.
- Acceptance: the edge where state=IDLE and start=1 (call it edge 0). op_code, both addresses and data_in are latched. start while busy=1 is ignored and not queued.
- FSM states: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WR_A, WR_B, DONE.
- Read phase, RD_x:
  - one cycle with sram_ren=1 and sram_addr=address.
  - WAIT_x then runs for RD_LAT cycles, counter loaded with RD_LAT.
  - sram_rdata is captured on the last WAIT_x edge.
  - A read phase is RD_LAT+1 cycles.
- Write phase, WR_x: one cycle with sram_wen=1, sram_addr and sram_wdata driven.
- ren and wen are never high together. sram_addr and sram_wdata are 0 when both are low.
- READ:
  - sequence RD_A, WAIT_A, DONE.
  - data_out = mem[a1]; done in cycle RD_LAT+2.
- WRITE:
  - sequence WR_A (wdata=data_in), DONE.
  - done in cycle 2; data_out unchanged.
- COPY:
  - sequence RD_A, WAIT_A, WR_B (mem[a2]=mem[a1]), DONE.
  - data_out = copied word; done in cycle RD_LAT+3.
- DONE: one cycle, done=1, then IDLE. busy falls in the cycle after DONE. data_out holds its value until the next capture.
- a1==a2: COPY and SWAP run the full sequence; memory contents end unchanged.
- Address arithmetic: none; addresses are used as given, with no wrap or offset.

Optional Feature:
- Macro: DATAPATH_SWAP_EN
- Defined, SWAP sequence: RD_A, WAIT_A, RD_B, WAIT_B, WR_A (writes old a2 word), WR_B (writes old a1 word), DONE.
  - data_out = old mem[a1]; err=0.
  - done in cycle 2*RD_LAT+5.
- Undefined: op 11 is illegal. The FSM goes IDLE to DONE with no SRAM access; done=1 and err=1 in cycle 1; data_out unchanged.
- Two DATA_W temp registers exist only when the macro is defined.

Decomposition:
- datapath_pkg holds:
  - typedef enum logic [1:0] op_t: OP_READ, OP_WRITE, OP_COPY, OP_SWAP.
  - typedef enum state_t for the eight FSM states.
- Sub-module flex_counter: parametrised down-counter for the WAIT_x latency, with load, enable and zero flag. It is reused by both wait states.

Test Plan:
- RD_LAT=1: WRITE a1=0x05 data 0xDEADBEEF, then READ a1=0x05 -> wen pulse in cycle 1; read done in cycle 3 with data_out=0xDEADBEEF, err=0.
- RD_LAT=3: COPY a1=0x10 (holds 0x12345678) to a2=0x7F -> ren cycle 1, wen at 0x7F with 0x12345678 in cycle 5, done in cycle 6, mem[0x7F]=0x12345678.
- start pulsed during a COPY, then again after busy falls -> first extra start ignored (no SRAM activity); second accepted normally.
- n_rst asserted in a WAIT_A cycle of COPY -> outputs 0 immediately, no wen ever issued, mem[a2] unchanged; next READ after release works.
- SWAP_EN defined, RD_LAT=1: mem[1]=0xA, mem[2]=0xB, SWAP -> done in cycle 7, mem[1]=0xB, mem[2]=0xA, data_out=0xA. Same address (a1=a2=1): mem[1] unchanged.
- SWAP_EN undefined: op 11 -> done and err=1 in cycle 1, no ren/wen, data_out unchanged.
